mux_scan_ctrl: RTL and testbench
================================

Name: mux_scan_ctrl

Overview:
Scan controller for the 64-to-1 mux tree built from mux2to1 stages.
- Upstream side: drives the tree select.
- Downstream side: consumes the registered tree output and tags each sample with its channel number.
- Output: a valid/ready stream of {channel, data}.
- Credit-limits in-flight selects so results are never dropped under backpressure.

Parameters:
N_CH, 64, number of mux inputs (power of 2, >=2)
DW, 8, data width of each channel
SEL_W, $clog2(N_CH), width of select and channel tag
MUX_LAT, 6, cycles from mux_sel register update to valid mux_data (one per registered tree level)
FIFO_DEPTH, 8, result buffer entries; must be >= MUX_LAT+1

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
start  input  1  begin a scan; sampled only in IDLE
stop  input  1  abort issuing; sampled only in SCAN
ch_mask  input  N_CH  bit i=1 enables channel i; sampled every SCAN cycle
mux_sel  output  SEL_W  registered select to mux tree
mux_data  input  DW  registered mux tree output
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_chan  output  SEL_W  channel of head result
out_data  output  DW  data of head result
busy  output  1  high whenever state != IDLE
scan_done  output  1  one-cycle pulse at return to IDLE

Behaviour:
- Reset values: mux_sel=0, out_valid=0, out_chan=0, out_data=0, busy=0, scan_done=0. Reset also clears FSM to IDLE, the index counter, the tag pipeline and the FIFO.
- Reset mid-scan discards all in-flight and buffered results.
- FSM states: IDLE, SCAN, DRAIN.
- IDLE -> SCAN: on start=1 and stop=0. Index counter is set to 0.
- IDLE with start=1 and stop=1: remain in IDLE.
- SCAN: one channel is examined per cycle at index idx.
  - If ch_mask[idx]=1 and credit is available, the channel is issued: mux_sel<=idx, and a tag {valid=1, idx} enters a MUX_LAT-deep shift pipeline. idx then advances.
  - If ch_mask[idx]=0, idx advances with no issue; a masked channel costs one cycle.
  - If the channel is enabled but no credit is available, idx holds and nothing is issued (stall).
- Credit rule: issue only when fifo_count + inflight_count < FIFO_DEPTH. The FIFO therefore never overflows.
- SCAN -> DRAIN: on the cycle idx=N_CH-1 is consumed (issued or skipped), or on stop=1. With stop, no issue occurs in that cycle.
- DRAIN: no issues. When the tag pipeline and FIFO are both empty, go to IDLE and pulse scan_done for one cycle.
- Timing: mux_sel updates at edge k. The tag exits the pipeline and mux_data is captured into the FIFO at edge k+MUX_LAT. out_valid is high after that edge (no bypass).
- First result: start sampled at edge s; first issue at edge s+1; out_valid first high after edge s+1+MUX_LAT.
- FIFO: out_chan and out_data present the head entry; out_valid = not empty.
  - Pop on out_valid and out_ready.
  - Push and pop in the same cycle are allowed at any occupancy, including full and single-entry.
- Ordering: results emerge in issue order, i.e. ascending channel order within a pass.
- mux_sel holds its last issued value while not issuing.
- Boundary: an all-zero mask yields N_CH skip cycles, DRAIN, then scan_done with no outputs.

Optional Feature:
SCAN_CONT_EN:
- Defined: after idx=N_CH-1, idx wraps to 0 and SCAN continues. Only stop leaves SCAN (to DRAIN). scan_done fires only after a stop-initiated drain.
- Undefined: single pass exactly as described in Behaviour.

Test Plan:
- Mux model mux_data=(sel*3)&0xFF with MUX_LAT delay; ch_mask all ones; out_ready=1; start at edge s -> 64 results, chan 0..63, data 0,3,...,189. First out_valid after edge s+7. scan_done once, after the last pop.
- ch_mask=64'h5 (channels 0 and 2), out_ready=1 -> exactly two results, (0,0x00) then (2,0x06). scan_done after the scan completes and both are popped.
- out_ready=0 throughout, full mask -> mux_sel stops at 7 and FIFO holds 8 entries. Raise out_ready -> all 64 results in order, none lost or duplicated.
- stop pulsed 10 cycles into the scan, out_ready=1 -> no new mux_sel changes after stop. All already-issued results delivered, then scan_done.
- rst asserted mid-scan with FIFO non-empty -> all outputs at reset values immediately and FIFO empty. A new start runs a clean full scan.
- With SCAN_CONT_EN, full mask, 150 cycles, then stop -> channel sequence 0..63,0..63,0.. with no gaps, scan_done only after the drain.

Source files
------------

// File: rtl/mux_scan_if.sv
// Scan controller bus: run control, mux tree select/data and the tagged result stream.
// master = scan controller side, slave = environment (mux tree, consumer, host).
interface mux_scan_if #(
    parameter int N_CH  = 64,
    parameter int DW    = 8,
    parameter int SEL_W = $clog2(N_CH)
);
    logic              start;
    logic              stop;
    logic [N_CH-1:0]   ch_mask;
    logic [SEL_W-1:0]  mux_sel;
    logic [DW-1:0]     mux_data;
    logic              out_valid;
    logic              out_ready;
    logic [SEL_W-1:0]  out_chan;
    logic [DW-1:0]     out_data;
    logic              busy;
    logic              scan_done;

    modport master (
        input  start, stop, ch_mask, mux_data, out_ready,
        output mux_sel, out_valid, out_chan, out_data, busy, scan_done
    );

    modport slave (
        output start, stop, ch_mask, mux_data, out_ready,
        input  mux_sel, out_valid, out_chan, out_data, busy, scan_done
    );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Credit-limited scan controller for a registered 64-to-1 mux tree; tags each sample with its channel.
// Optional SCAN_CONT_EN: continuous wrap-around scanning until stop (default: single pass).
module mux_scan_ctrl #(
    parameter int N_CH       = 64,
    parameter int DW         = 8,
    parameter int SEL_W      = $clog2(N_CH),
    parameter int MUX_LAT    = 6,
    parameter int FIFO_DEPTH = 8
) (
    input  logic      clk,
    input  logic      rst,
    mux_scan_if.master bus
);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int ICNT_W = $clog2(MUX_LAT + 1);
    localparam int SUM_W  = $clog2(FIFO_DEPTH + MUX_LAT + 1);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    typedef struct packed {
        logic [SEL_W-1:0] chan;
        logic [DW-1:0]    data;
    } entry_t;

    state_t            state;
    logic [SEL_W-1:0]  idx;
    logic [MUX_LAT-1:0] tag_vld;
    logic [SEL_W-1:0]  tag_ch [MUX_LAT];
    logic [ICNT_W-1:0] inflight;
    entry_t            mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [FCNT_W-1:0] fifo_count;

    logic credit_ok, scanning, ch_en, issue, advance, push, pop;

    // NOTE: every always_comb output gets a value before any condition, so no latch can be inferred.
    always_comb begin
        credit_ok = (SUM_W'(fifo_count) + SUM_W'(inflight)) < SUM_W'(FIFO_DEPTH);
        scanning  = (state == SCAN) && !bus.stop;
        ch_en     = bus.ch_mask[idx];
        issue     = scanning && ch_en && credit_ok;
        advance   = scanning && (!ch_en || credit_ok);
        push      = tag_vld[MUX_LAT-1];
        pop       = bus.out_valid && bus.out_ready;
    end

    assign bus.out_valid = (fifo_count != '0);
    assign bus.out_chan  = bus.out_valid ? mem[rd_ptr].chan : '0;
    assign bus.out_data  = bus.out_valid ? mem[rd_ptr].data : '0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            idx           <= '0;
            bus.mux_sel   <= '0;
            bus.busy      <= 1'b0;
            bus.scan_done <= 1'b0;
        end else begin
            bus.scan_done <= 1'b0;
            if (issue) bus.mux_sel <= idx;
            unique case (state)
                IDLE: begin
                    if (bus.start && !bus.stop) begin
                        state    <= SCAN;
                        idx      <= '0;
                        bus.busy <= 1'b1;
                    end
                end
                SCAN: begin
                    if (bus.stop) begin
                        state <= DRAIN;
                    end else if (advance) begin
                        // N_CH is a power of two, so the increment wraps to 0 on its own.
                        idx <= idx + SEL_W'(1);
`ifdef SCAN_CONT_EN
`else
                        if (idx == SEL_W'(N_CH - 1)) state <= DRAIN;
`endif
                    end
                end
                DRAIN: begin
                    if (inflight == '0 && fifo_count == '0) begin
                        state         <= IDLE;
                        bus.busy      <= 1'b0;
                        bus.scan_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Channel tags travel alongside the tree so each captured sample knows its source.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_vld  <= '0;
            inflight <= '0;
            for (int i = 0; i < MUX_LAT; i++) tag_ch[i] <= '0;
        end else begin
            tag_vld   <= {tag_vld[MUX_LAT-2:0], issue};
            tag_ch[0] <= idx;
            for (int i = 1; i < MUX_LAT; i++) tag_ch[i] <= tag_ch[i-1];
            unique case ({issue, push})
                2'b10:   inflight <= inflight + ICNT_W'(1);
                2'b01:   inflight <= inflight - ICNT_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + FCNT_W'(1);
                2'b01:   fifo_count <= fifo_count - FCNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{chan: tag_ch[MUX_LAT-1], data: bus.mux_data};
    end
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl: registered mux tree model, result scoreboard, random masks/backpressure.
// Build with +define+SCAN_CONT_EN to exercise the continuous-scan variant instead of the single-pass plan.
module tb_mux_scan_ctrl;
    localparam int N_CH    = 64;
    localparam int DW      = 8;
    localparam int SEL_W   = 6;
    localparam int MUX_LAT = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mux_scan_if #(.N_CH(N_CH), .DW(DW)) bus ();

    mux_scan_ctrl #(.N_CH(N_CH), .DW(DW), .MUX_LAT(MUX_LAT), .FIFO_DEPTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    // Mux tree model: data = sel*3, valid for capture MUX_LAT edges after the select register updates.
    logic [SEL_W-1:0] sel_pipe [MUX_LAT-1];
    always @(posedge clk) begin
        sel_pipe[0] <= bus.mux_sel;
        for (int i = 1; i < MUX_LAT - 1; i++) sel_pipe[i] <= sel_pipe[i-1];
    end
    assign bus.mux_data = 8'(32'(sel_pipe[MUX_LAT-2]) * 3);

    typedef struct {
        int ch;
        int d;
    } res_t;

    res_t exp_q[$];
    res_t obs_q[$];
    int   done_cnt = 0;
    int   n_checks = 0;
    int   n_err    = 0;
    int   obs_base, done_base;

    // Observer: record every accepted result and every scan_done pulse.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready)
            obs_q.push_back('{int'(bus.out_chan), int'(bus.out_data)});
        if (!rst && bus.scan_done) done_cnt++;
    end

    task automatic check(input string tag, input longint got, input longint want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic void expect_chan(input int ch);
        exp_q.push_back('{ch, (ch * 3) & 8'hFF});
    endfunction

    function automatic void expect_mask(input logic [N_CH-1:0] m);
        for (int i = 0; i < N_CH; i++) if (m[i]) expect_chan(i);
    endfunction

    // Leaves the bench 1 time unit after the edge that samples start.
    task automatic start_scan(input logic [N_CH-1:0] m);
        obs_base    = obs_q.size();
        done_base   = done_cnt;
        bus.ch_mask = m;
        bus.start   = 1'b1;
        @(posedge clk); #1;
        bus.start   = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd, output int cycles);
        int c = 0;
        while (!bus.scan_done && c < budget) begin
            @(posedge clk); #1;
            c++;
            if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
        end
        check("done_seen", longint'(c < budget), 1);
        @(posedge clk); #1;
        check("done_pulse", bus.scan_done, 0);
        check("idle_busy", bus.busy, 0);
        check("done_count", done_cnt - done_base, 1);
        check("n_results", obs_q.size() - obs_base, exp_q.size());
        for (int i = 0; i < exp_q.size() && obs_base + i < obs_q.size(); i++) begin
            check("res_chan", obs_q[obs_base+i].ch, exp_q[i].ch);
            check("res_data", obs_q[obs_base+i].d, exp_q[i].d);
        end
        exp_q.delete();
        cycles = c;
    endtask

    task automatic check_reset_values();
        check("rst_mux_sel", bus.mux_sel, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_chan", bus.out_chan, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_scan_done", bus.scan_done, 0);
    endtask

    initial begin
        int n;
        int cyc;
        logic [N_CH-1:0] m;
        bus.start = 1'b0; bus.stop = 1'b0; bus.ch_mask = '0; bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values();
        rst = 1'b0;
        @(posedge clk); #1;

`ifdef SCAN_CONT_EN
        // Continuous: 150 issues (channel i%64) before stop is sampled, scan_done only after drain.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 150; i++) expect_chan(i % N_CH);
        start_scan('1);
        repeat (150) begin @(posedge clk); #1; end
        check("cont_no_early_done", done_cnt - done_base, 0);
        check("cont_busy", bus.busy, 1);
        bus.stop = 1'b1;
        @(posedge clk); #1;
        bus.stop = 1'b0;
        wait_done(200, 1'b0, cyc);
`else
        // Full mask, free-flowing consumer: latency of first result and full ordered pass.
        bus.out_ready = 1'b1;
        expect_mask('1);
        start_scan('1);
        check("busy_after_start", bus.busy, 1);
        n = 0;
        while (!bus.out_valid && n < 20) begin @(posedge clk); #1; n++; end
        check("first_valid_latency", n, 7);
        wait_done(300, 1'b0, cyc);

        // start together with stop leaves the controller idle.
        bus.start = 1'b1; bus.stop = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.stop = 1'b0;
        check("start_stop_idle", bus.busy, 0);

        // Sparse mask: channels 0 and 2 only.
        expect_mask(64'h5);
        start_scan(64'h5);
        wait_done(300, 1'b0, cyc);

        // All-zero mask: N_CH skip cycles, one drain cycle, no results.
        start_scan('0);
        wait_done(300, 1'b0, cyc);
        check("zero_mask_cycles", cyc, N_CH + 1);

        // Consumer stalled: credit allows exactly FIFO_DEPTH issues, then release.
        bus.out_ready = 1'b0;
        expect_mask('1);
        start_scan('1);
        repeat (30) begin @(posedge clk); #1; end
        check("stall_mux_sel", bus.mux_sel, 7);
        check("stall_valid", bus.out_valid, 1);
        check("stall_head_chan", bus.out_chan, 0);
        check("stall_pops", obs_q.size() - obs_base, 0);
        bus.out_ready = 1'b1;
        wait_done(600, 1'b0, cyc);

        // Stop sampled on the 11th SCAN edge: channels 0..9 issued, nothing after.
        for (int i = 0; i < 10; i++) expect_chan(i);
        start_scan('1);
        repeat (10) begin @(posedge clk); #1; end
        bus.stop = 1'b1;
        @(posedge clk); #1;
        bus.stop = 1'b0;
        check("stop_mux_sel", bus.mux_sel, 9);
        repeat (3) begin @(posedge clk); #1; end
        check("stop_mux_sel_hold", bus.mux_sel, 9);
        wait_done(100, 1'b0, cyc);

        // Reset mid-scan with buffered results, then a clean pass under random backpressure.
        bus.out_ready = 1'b0;
        start_scan('1);
        repeat (15) begin @(posedge clk); #1; end
        check("pre_rst_valid", bus.out_valid, 1);
        rst = 1'b1;
        #1;
        check_reset_values();
        @(posedge clk); #1;
        rst = 1'b0;
        expect_mask('1);
        start_scan('1);
        wait_done(2000, 1'b1, cyc);

        // Random masks under random backpressure.
        for (int it = 0; it < 4; it++) begin
            m = {$urandom, $urandom};
            bus.out_ready = 1'($urandom_range(0, 1));
            expect_mask(m);
            start_scan(m);
            wait_done(3000, 1'b1, cyc);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
